// File: rtl/demux4_stream_pkg.sv
// demux4_stream_pkg: shared state encodings and sizes for the stream demux
package demux4_stream_pkg;
  localparam int NUM_OUT = 4;
  localparam int SEL_W = 2;
  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } state_t;
endpackage

// File: rtl/demux4_stream_dec.sv
// onehot_dec4: 2-bit index to 4-bit one-hot with enable
module onehot_dec4 (
  input  logic       en,
  input  logic [1:0] sel,
  output logic [3:0] y
);
  assign y = en ? 4'b0001 << sel : 4'b0000;
endmodule

// File: rtl/demux4_stream_mux2.sv
// mux2: parameterised 2-input select mux
module mux2 #(
  parameter int width = 32
) (
  input  logic             sel,
  input  logic [width-1:0] a,
  input  logic [width-1:0] b,
  output logic [width-1:0] y
);
  assign y = sel ? b : a;
endmodule

// File: rtl/demux4_stream.sv
// demux4_stream: 1-to-4 stream demux behind a 2-entry elastic buffer
module demux4_stream
  import demux4_stream_pkg::*;
#(
  parameter int width = 32
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [width-1:0]   in_data,
  input  logic [SEL_W-1:0]   in_select,
  input  logic               in_valid,
  output logic               in_ready,
  output logic [width-1:0]   out_data,
  output logic [NUM_OUT-1:0] out_valid,
  input  logic [NUM_OUT-1:0] out_ready,
  output logic [1:0]         occupancy
);
  state_t state;
  logic wp, rp, push, pop, nonempty;
  logic [width+SEL_W-1:0] entry [2];
  logic [width+SEL_W-1:0] head;
  assign in_ready = state != ST_FULL;
  assign nonempty = state != ST_EMPTY;
  assign push = in_valid & in_ready;
  assign pop = |(out_valid & out_ready);
  assign occupancy = state;
  assign out_data = nonempty ? head[width+SEL_W-1:SEL_W] : '0;
  mux2 #(.width(width + SEL_W)) u_head (
    .sel(rp),
    .a  (entry[0]),
    .b  (entry[1]),
    .y  (head)
  );
  onehot_dec4 u_dec (
    .en (nonempty),
    .sel(head[SEL_W-1:0]),
    .y  (out_valid)
  );
  // buffer storage, pointers and occupancy state; head-of-line order is preserved
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= ST_EMPTY;
      wp       <= 1'b0;
      rp       <= 1'b0;
      entry[0] <= '0;
      entry[1] <= '0;
    end else begin
      if (push) entry[wp] <= {in_data, in_select};
      wp <= wp ^ push;
      rp <= rp ^ pop;
      case (state)
        ST_EMPTY: state <= push ? ST_ONE : ST_EMPTY;
        ST_ONE:   state <= (push & ~pop) ? ST_FULL : (~push & pop) ? ST_EMPTY : ST_ONE;
        ST_FULL:  state <= pop ? ST_ONE : ST_FULL;
        default:  state <= ST_EMPTY;
      endcase
    end
  end
endmodule

// File: tb/tb_demux4_stream.sv
// tb_demux4_stream: directed scenario checks for demux4_stream
module tb_demux4_stream;
  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] in_data;
  logic [1:0]  in_select;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] out_data;
  logic [3:0]  out_valid;
  logic [3:0]  out_ready;
  logic [1:0]  occupancy;
  int passed = 0;
  int total = 0;

  demux4_stream #(.width(32)) dut (
    .clk      (clk),
    .reset    (reset),
    .in_data  (in_data),
    .in_select(in_select),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .out_data (out_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .occupancy(occupancy)
  );

  always #5 clk = ~clk;

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    total++; if (out_valid !== 4'b0000) $display("FAIL rst_valid: got %b want 0000", out_valid); else passed++;
    total++; if (occupancy !== 2'd0) $display("FAIL rst_occ: got %0d want 0", occupancy); else passed++;
    total++; if (out_data !== 32'h0) $display("FAIL rst_data: got %h want 0", out_data); else passed++;
    total++; if (in_ready !== 1'b1) $display("FAIL rst_ready: got %b want 1", in_ready); else passed++;
  endtask

  task automatic test_reset_mid;
    out_ready = 4'b0000;
    in_valid = 1'b1; in_data = 32'hAAAA0001; in_select = 2'd1;
    step;
    in_data = 32'hAAAA0002; in_select = 2'd2;
    step;
    in_valid = 1'b0;
    total++; if (occupancy !== 2'd2) $display("FAIL mid_fill_occ: got %0d want 2", occupancy); else passed++;
    total++; if (in_ready !== 1'b0) $display("FAIL mid_fill_ready: got %b want 0", in_ready); else passed++;
    total++; if (out_valid !== 4'b0010 || out_data !== 32'hAAAA0001) $display("FAIL mid_fill_head: got %b/%h want 0010/aaaa0001", out_valid, out_data); else passed++;
    #2 reset = 1'b1;
    #1;
    total++; if (out_valid !== 4'b0000) $display("FAIL mid_rst_valid: got %b want 0000", out_valid); else passed++;
    total++; if (occupancy !== 2'd0) $display("FAIL mid_rst_occ: got %0d want 0", occupancy); else passed++;
    total++; if (out_data !== 32'h0) $display("FAIL mid_rst_data: got %h want 0", out_data); else passed++;
    #2 reset = 1'b0;
    step;
    total++; if (in_ready !== 1'b1) $display("FAIL mid_post_ready: got %b want 1", in_ready); else passed++;
    total++; if (occupancy !== 2'd0) $display("FAIL mid_post_occ: got %0d want 0", occupancy); else passed++;
  endtask

  task automatic test_single;
    out_ready = 4'b0000;
    in_valid = 1'b1; in_data = 32'h12345678; in_select = 2'd2;
    step;
    in_valid = 1'b0;
    total++; if (out_valid !== 4'b0100 || out_data !== 32'h12345678) $display("FAIL single_head: got %b/%h want 0100/12345678", out_valid, out_data); else passed++;
    for (int i = 0; i < 3; i++) begin
      in_data = 32'hDEAD0000 + i; in_select = 2'(i);
      step;
      total++; if (out_valid !== 4'b0100 || out_data !== 32'h12345678) $display("FAIL single_hold%0d: got %b/%h want 0100/12345678", i, out_valid, out_data); else passed++;
    end
    out_ready = 4'b0100;
    step;
    out_ready = 4'b0000;
    total++; if (out_valid !== 4'b0000 || occupancy !== 2'd0) $display("FAIL single_pop: got %b/%0d want 0000/0", out_valid, occupancy); else passed++;
  endtask

  task automatic test_wrong_ready;
    in_valid = 1'b1; in_data = 32'h0000C0DE; in_select = 2'd3;
    step;
    in_valid = 1'b0;
    out_ready = 4'b0111;
    for (int i = 0; i < 4; i++) begin
      step;
      total++; if (occupancy !== 2'd1 || out_valid !== 4'b1000) $display("FAIL wrong_hold%0d: got %0d/%b want 1/1000", i, occupancy, out_valid); else passed++;
    end
    out_ready = 4'b1000;
    step;
    out_ready = 4'b0000;
    total++; if (occupancy !== 2'd0 || out_valid !== 4'b0000) $display("FAIL wrong_pop: got %0d/%b want 0/0000", occupancy, out_valid); else passed++;
  endtask

  task automatic test_full;
    out_ready = 4'b0000;
    in_valid = 1'b1; in_data = 32'h1; in_select = 2'd0;
    step;
    in_data = 32'h2; in_select = 2'd1;
    step;
    total++; if (occupancy !== 2'd2 || in_ready !== 1'b0) $display("FAIL full_state: got %0d/%b want 2/0", occupancy, in_ready); else passed++;
    in_data = 32'h3; in_select = 2'd2;
    step;
    total++; if (occupancy !== 2'd2 || out_data !== 32'h1 || out_valid !== 4'b0001) $display("FAIL full_reject: got %0d/%h/%b want 2/1/0001", occupancy, out_data, out_valid); else passed++;
    out_ready = 4'b1111;
    step;
    total++; if (out_data !== 32'h2 || out_valid !== 4'b0010 || occupancy !== 2'd1 || in_ready !== 1'b1) $display("FAIL full_drain1: got %h/%b/%0d/%b want 2/0010/1/1", out_data, out_valid, occupancy, in_ready); else passed++;
    step;
    in_valid = 1'b0;
    total++; if (out_data !== 32'h3 || out_valid !== 4'b0100 || occupancy !== 2'd1) $display("FAIL full_drain2: got %h/%b/%0d want 3/0100/1", out_data, out_valid, occupancy); else passed++;
    step;
    out_ready = 4'b0000;
    total++; if (occupancy !== 2'd0 || out_valid !== 4'b0000) $display("FAIL full_empty: got %0d/%b want 0/0000", occupancy, out_valid); else passed++;
  endtask

  task automatic test_throughput;
    logic [3:0] exp_valid;
    out_ready = 4'b1111;
    for (int i = 0; i < 16; i++) begin
      in_valid = 1'b1; in_data = 32'h100 + i; in_select = 2'(i % 4);
      step;
      exp_valid = 4'b0001 << (i % 4);
      total++; if (out_data !== 32'h100 + i || out_valid !== exp_valid || occupancy !== 2'd1 || in_ready !== 1'b1) $display("FAIL thru%0d: got %h/%b/%0d/%b want %h/%b/1/1", i, out_data, out_valid, occupancy, in_ready, 32'h100 + i, exp_valid); else passed++;
    end
    in_valid = 1'b0;
    step;
    out_ready = 4'b0000;
    total++; if (occupancy !== 2'd0) $display("FAIL thru_drain: got %0d want 0", occupancy); else passed++;
  endtask

  task automatic test_push_pop_one;
    out_ready = 4'b0000;
    in_valid = 1'b1; in_data = 32'hA; in_select = 2'd0;
    step;
    in_data = 32'hB; in_select = 2'd3; out_ready = 4'b0001;
    step;
    in_valid = 1'b0; out_ready = 4'b0000;
    total++; if (occupancy !== 2'd1 || out_data !== 32'hB || out_valid !== 4'b1000) $display("FAIL pp_head: got %0d/%h/%b want 1/b/1000", occupancy, out_data, out_valid); else passed++;
    out_ready = 4'b1000;
    step;
    out_ready = 4'b0000;
    total++; if (occupancy !== 2'd0) $display("FAIL pp_drain: got %0d want 0", occupancy); else passed++;
  endtask

  initial begin
    reset = 1'b1; in_valid = 1'b0; in_data = '0; in_select = '0; out_ready = '0;
    #12;
    test_reset;
    #2 reset = 1'b0;
    step;
    test_reset;
    test_reset_mid;
    test_single;
    test_wrong_ready;
    test_full;
    test_throughput;
    test_push_pop_one;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
